fetch_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_out_stage.sv | 57 +++++
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state
// encoding, the program-counter step and the default halt encoding.
package fetch_pkg;

   // FAULT is only ever entered when the fault check is compiled in.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] PC_STEP           = 32'd4;
   localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_out_stage.sv
// One-entry valid/ready output register holding the fetched word and the
// address it came from. Flush beats load, and load beats consume, so a
// simultaneous consume and load keeps the stage full with the new word.
module fetch_out_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        consume,
   input  logic        flush,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid
);

   logic [31:0] instr_q;
   logic [31:0] instr_d;
   logic [31:0] instr_pc_q;
   logic [31:0] instr_pc_d;
   logic        valid_q;
   logic        valid_d;

   // Next contents of the slot: flush drops it, load refills it, consume empties it.
   always_comb begin
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         instr_d    = load_instr;
         instr_pc_d = load_pc;
         valid_d    = 1'b1;
      end else if (consume) begin
         valid_d = 1'b0;
      end
   end

   // Slot registers with synchronous reset to an empty, zeroed entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q    <= 32'd0;
         instr_pc_q <= 32'd0;
         valid_q    <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
      end
   end

   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the program counter, addresses the combinational
// instruction memory and registers each word into a valid/ready stage.
// Optional build macro FETCH_FAULT_EN adds a misaligned/out-of-range PC
// check that parks the sequencer in FAULT until reset.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD,
   parameter int          MEM_BYTES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [31:0] mem_address,
   input  logic [31:0] mem_data,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic        fault
);

   fetch_state_e state_q;
   fetch_state_e state_d;
   logic [31:0]  pc_q;
   logic [31:0]  pc_d;
   logic         load;
   logic         flush;
   logic         consume;
   logic         slot_free;
   logic         bad_pc;

   assign slot_free = !instr_valid || instr_ready;
   assign consume   = instr_valid && instr_ready;

`ifdef FETCH_FAULT_EN
   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   // A PC is unusable if it is not word aligned or lies past the end of memory.
   always_comb begin
      bad_pc = (pc_q[1:0] != 2'b00) || (pc_q >= MEM_LIMIT);
   end
`else
   // Without the fault check every address is passed through; MEM_BYTES is unused.
   logic unused_mem_bytes;
   assign unused_mem_bytes = ^(32'(MEM_BYTES));
   assign bad_pc           = 1'b0;
`endif

   // Next-state, next-PC and output-stage control; redirect outranks everything.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      load    = 1'b0;
      flush   = 1'b0;
      case (state_q)
         IDLE: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               flush   = 1'b1;
               state_d = RUN;
            end else if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               flush   = 1'b1;
            end else if (slot_free) begin
               if (bad_pc) begin
`ifdef FETCH_FAULT_EN
                  state_d = FAULT;
`endif
               end else begin
                  load = 1'b1;
                  if (mem_data == HALT_WORD) begin
                     state_d = HALT;
                  end else begin
                     pc_d = pc_q + PC_STEP;
                  end
               end
            end
         end
         HALT: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               flush   = 1'b1;
               state_d = RUN;
            end
         end
`ifdef FETCH_FAULT_EN
         FAULT: begin
            state_d = FAULT;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and PC registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_out_stage u_out_stage (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .consume     (consume),
      .flush       (flush),
      .load_instr  (mem_data),
      .load_pc     (pc_q),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid)
   );

   assign mem_address = pc_q;
   assign halted      = (state_q == HALT);
`ifdef FETCH_FAULT_EN
   assign fault       = (state_q == FAULT);
`else
   assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: a table of per-cycle vectors for
// the main stream, stall, redirect and halt behaviour, then hand sequences
// for the address-check corner cases (with and without FETCH_FAULT_EN).
module tb_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] mem_address;
   logic [31:0] mem_data;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
   logic        fault;

   int checks;
   int failures;

   logic [31:0] mem [16];

   fetch_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .mem_address    (mem_address),
      .mem_data       (mem_data),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .fault          (fault)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational instruction memory; addresses beyond 64 bytes return a
   // recognisable pattern so unchecked fetches are visible.
   always_comb begin
      if (mem_address < 32'd64) mem_data = mem[mem_address[5:2]];
      else                      mem_data = 32'h0BAD_0000 ^ mem_address;
   end

   typedef struct packed {
      logic        rst;
      logic        st;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        chk_data;
      logic [31:0] e_instr;
      logic [31:0] e_ipc;
      logic        e_valid;
      logic [31:0] e_addr;
      logic        e_halted;
   } vec_t;

   localparam int NVEC = 28;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic rst, input logic st, input logic rdy,
                               input logic rv, input logic [31:0] rpc,
                               input logic chk_data, input logic [31:0] e_instr,
                               input logic [31:0] e_ipc, input logic e_valid,
                               input logic [31:0] e_addr, input logic e_halted);
      vec_t v;
      v.rst = rst; v.st = st; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.chk_data = chk_data; v.e_instr = e_instr; v.e_ipc = e_ipc;
      v.e_valid = e_valid; v.e_addr = e_addr; v.e_halted = e_halted;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, let a rising edge pass,
   // and return at the next falling edge with outputs settled.
   task automatic apply_stimulus(input logic rst, input logic st, input logic rdy,
                                 input logic rv, input logic [31:0] rpc);
      reset          = rst;
      start          = st;
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_output(input string name, input logic chk_data,
                               input logic [31:0] e_instr, input logic [31:0] e_ipc,
                               input logic e_valid, input logic [31:0] e_addr,
                               input logic e_halted, input logic e_fault);
      if (chk_data) begin
         cmp({name, ".instr"}, instr, e_instr);
         cmp({name, ".instr_pc"}, instr_pc, e_ipc);
      end
      cmp({name, ".instr_valid"}, 32'(instr_valid), 32'(e_valid));
      cmp({name, ".mem_address"}, mem_address, e_addr);
      cmp({name, ".halted"}, 32'(halted), 32'(e_halted));
      cmp({name, ".fault"}, 32'(fault), 32'(e_fault));
   endtask

   localparam logic [31:0] HW = 32'hFFFF_FFFF;

   initial begin
      checks         = 0;
      failures       = 0;
      reset          = 1'b1;
      start          = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;

      for (int i = 0; i < 16; i++) mem[i] = 32'h100 + 32'(i);
      mem[0]  = 32'h11;
      mem[1]  = 32'h22;
      mem[2]  = 32'h33;
      mem[3]  = 32'h44;
      mem[4]  = HW;
      mem[12] = 32'hC0;

      //            rst  st   rdy  rv   rpc           chk  instr  ipc   v    addr  h
      vecs[0]  = mk(1'b1,1'b0,1'b1,1'b0,32'd0,        1'b1,32'h0, 32'd0, 1'b0,32'd0, 1'b0);
      vecs[1]  = mk(1'b0,1'b1,1'b1,1'b0,32'd0,        1'b1,32'h0, 32'd0, 1'b0,32'd0, 1'b0);
      vecs[2]  = mk(1'b0,1'b0,1'b1,1'b0,32'd0,        1'b1,32'h11,32'd0, 1'b1,32'd4, 1'b0);
      vecs[3]  = mk(1'b0,1'b0,1'b1,1'b0,32'd0,        1'b1,32'h22,32'd4, 1'b1,32'd8, 1'b0);
      vecs[4]  = mk(1'b0,1'b0,1'b1,1'b0,32'd0,        1'b1,32'h33,32'd8, 1'b1,32'd12,1'b0);
      vecs[5]  = mk(1'b1,1'b0,1'b0,1'b0,32'd0,        1'b1,32'h0, 32'd0, 1'b0,32'd0, 1'b0);
      vecs[6]  = mk(1'b0,1'b0,1'b1,1'b0,32'd0,        1'b1,32'h0, 32'd0, 1'b0,32'd0, 1'b0);
      vecs[7]  = mk(1'b0,1'b1,1'b0,1'b0,32'd0,        1'b0,32'h0, 32'd0, 1'b0,32'd0, 1'b0);
      vecs[8]  = mk(1'b0,1'b0,1'b0,1'b0,32'd0,        1'b1,32'h11,32'd0, 1'b1,32'd4, 1'b0);
      vecs[9]  = mk(1'b0,1'b0,1'b0,1'b0,32'd0,        1'b1,32'h11,32'd0, 1'b1,32'd4, 1'b0);
      vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,32'd0,        1'b1,32'h11,32'd0, 1'b1,32'd4, 1'b0);
      vecs[11] = mk(1'b0,1'b0,1'b0,1'b0,32'd0,        1'b1,32'h11,32'd0, 1'b1,32'd4, 1'b0);
      vecs[12] = mk(1'b0,1'b0,1'b1,1'b0,32'd0,        1'b1,32'h22,32'd4, 1'b1,32'd8, 1'b0);
      vecs[13] = mk(1'b0,1'b0,1'b0,1'b1,32'd48,       1'b0,32'h0, 32'd0, 1'b0,32'd48,1'b0);
      vecs[14] = mk(1'b0,1'b0,1'b1,1'b0,32'd0,        1'b1,32'hC0,32'd48,1'b1,32'd52,1'b0);
      vecs[15] = mk(1'b0,1'b0,1'b1,1'b1,32'd8,        1'b0,32'h0, 32'd0, 1'b0,32'd8, 1'b0);
      vecs[16] = mk(1'b0,1'b0,1'b1,1'b0,32'd0,        1'b1,32'h33,32'd8, 1'b1,32'd12,1'b0);
      vecs[17] = mk(1'b0,1'b0,1'b1,1'b0,32'd0,        1'b1,32'h44,32'd12,1'b1,32'd16,1'b0);
      vecs[18] = mk(1'b0,1'b0,1'b1,1'b0,32'd0,        1'b1,HW,    32'd16,1'b1,32'd16,1'b1);
      vecs[19] = mk(1'b0,1'b0,1'b0,1'b0,32'd0,        1'b1,HW,    32'd16,1'b1,32'd16,1'b1);
      vecs[20] = mk(1'b0,1'b0,1'b1,1'b0,32'd0,        1'b0,32'h0, 32'd0, 1'b0,32'd16,1'b1);
      vecs[21] = mk(1'b0,1'b0,1'b1,1'b0,32'd0,        1'b0,32'h0, 32'd0, 1'b0,32'd16,1'b1);
      vecs[22] = mk(1'b0,1'b0,1'b1,1'b1,32'd0,        1'b0,32'h0, 32'd0, 1'b0,32'd0, 1'b0);
      vecs[23] = mk(1'b0,1'b0,1'b1,1'b0,32'd0,        1'b1,32'h11,32'd0, 1'b1,32'd4, 1'b0);
      vecs[24] = mk(1'b0,1'b1,1'b1,1'b0,32'd0,        1'b1,32'h22,32'd4, 1'b1,32'd8, 1'b0);
      vecs[25] = mk(1'b1,1'b0,1'b1,1'b0,32'd0,        1'b1,32'h0, 32'd0, 1'b0,32'd0, 1'b0);
      vecs[26] = mk(1'b0,1'b1,1'b1,1'b1,32'd20,       1'b0,32'h0, 32'd0, 1'b0,32'd20,1'b0);
      vecs[27] = mk(1'b0,1'b0,1'b1,1'b0,32'd0,        1'b1,32'h105,32'd20,1'b1,32'd24,1'b0);

      @(negedge clk);
      for (int i = 0; i < NVEC; i++) begin
         apply_stimulus(vecs[i].rst, vecs[i].st, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
         check_output($sformatf("vec%0d", i), vecs[i].chk_data, vecs[i].e_instr,
                      vecs[i].e_ipc, vecs[i].e_valid, vecs[i].e_addr,
                      vecs[i].e_halted, 1'b0);
      end

      // Redirect to the first byte past memory, then to a misaligned address.
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      check_output("seq_rst1", 1'b1, 32'h0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'd64);
      check_output("seq_redir64", 1'b0, 32'h0, 32'd0, 1'b0, 32'd64, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
`ifdef FETCH_FAULT_EN
      check_output("seq_fault64", 1'b0, 32'h0, 32'd0, 1'b0, 32'd64, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
      check_output("seq_fault64_redir", 1'b0, 32'h0, 32'd0, 1'b0, 32'd64, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      check_output("seq_fault64_hold", 1'b0, 32'h0, 32'd0, 1'b0, 32'd64, 1'b0, 1'b1);
`else
      check_output("seq_fetch64", 1'b1, 32'h0BAD_0040, 32'd64, 1'b1, 32'd68, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      check_output("seq_redir_top", 1'b0, 32'h0, 32'd0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      check_output("seq_wrap", 1'b1, 32'hF452_FFFC, 32'hFFFF_FFFC, 1'b1, 32'd0, 1'b0, 1'b0);
`endif
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      check_output("seq_rst2", 1'b1, 32'h0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'd6);
      check_output("seq_redir6", 1'b0, 32'h0, 32'd0, 1'b0, 32'd6, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
`ifdef FETCH_FAULT_EN
      check_output("seq_fault6", 1'b0, 32'h0, 32'd0, 1'b0, 32'd6, 1'b0, 1'b1);
`else
      check_output("seq_fetch6", 1'b1, 32'h22, 32'd6, 1'b1, 32'd10, 1'b0, 1'b0);
`endif
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      check_output("seq_rst3", 1'b1, 32'h0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
